// File: rtl/fifo_sync_buffer.sv
// ============================================================================
// fifo_sync_buffer
// ----------------------------------------------------------------------------
// Single-clock FIFO over one flat storage vector, with ready/valid handshakes
// on the write and read sides. Read data is first-word-fall-through: the head
// entry is driven combinationally from registered state.
//
// Optional build macro: FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
//   When defined, adds sticky overflow/underflow outputs. These are cleared
//   only by reset.
//
// Parameters:
//   DATA_WIDTH  bits per entry (>= 1)
//   DEPTH       number of entries (power of two, >= 2)
//
// Ports:
//   clk          in   system clock; all logic on the rising edge
//   reset        in   synchronous active-low reset
//   write_data   in   entry to enqueue
//   write_valid  in   producer offers write_data
//   write_ready  out  FIFO can accept an entry (not full)
//   read_data    out  head entry (0 when empty after reset)
//   read_valid   out  head entry is valid (not empty)
//   read_ready   in   consumer takes the head entry
//   count        out  number of stored entries, 0..DEPTH
//   full         out  count == DEPTH
//   empty        out  count == 0
//   overflow     out  (macro only) sticky: write_valid seen while full
//   underflow    out  (macro only) sticky: read_ready seen while empty
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge exactly when valid && ready are both
//   high. write_ready and read_valid depend only on registered state, never
//   on the opposite side's inputs. Therefore a full FIFO never bypasses a
//   write into a read slot, and an empty FIFO never bypasses a write to the
//   read port.
// ============================================================================
module fifo_sync_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic                       write_valid,
    output logic                       write_ready,
    output logic [DATA_WIDTH-1:0]      read_data,
    output logic                       read_valid,
    input  logic                       read_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
`ifdef FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ADDR_W = $clog2(DATA_WIDTH * DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int MEM_W  = DATA_WIDTH * DEPTH;

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [MEM_W-1:0]  storage_q, storage_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic wr_fire;
    logic rd_fire;

    // Status is decoded from the registered count, never stored separately.
    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign write_ready = !full;
    assign read_valid  = !empty;
    assign read_data   = storage_q[rd_addr_q +: DATA_WIDTH];

    assign wr_fire = write_valid && write_ready;
    assign rd_fire = read_valid && read_ready;

    always_comb begin
        storage_d = storage_q;
        wr_ptr_d  = wr_ptr_q;
        wr_addr_d = wr_addr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;

        if (wr_fire) begin
            storage_d[wr_addr_q +: DATA_WIDTH] = write_data;
            // Pointer and bit address move in lock-step. The pointer decides
            // the wrap, so the address never needs a magnitude compare
            // against a non-power-of-two bound.
            if (wr_ptr_q == PTR_LAST) begin
                wr_ptr_d  = '0;
                wr_addr_d = '0;
            end else begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                wr_addr_d = wr_addr_q + ADDR_STEP;
            end
        end

        if (rd_fire) begin
            if (rd_ptr_q == PTR_LAST) begin
                rd_ptr_d  = '0;
                rd_addr_d = '0;
            end else begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_addr_d = rd_addr_q + ADDR_STEP;
            end
        end

        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            storage_q <= '0;
            wr_ptr_q  <= '0;
            wr_addr_q <= '0;
            rd_ptr_q  <= '0;
            rd_addr_q <= '0;
            count_q   <= '0;
        end else begin
            storage_q <= storage_d;
            wr_ptr_q  <= wr_ptr_d;
            wr_addr_q <= wr_addr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_addr_q <= rd_addr_d;
            count_q   <= count_d;
        end
    end

`ifdef FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: they record a refused request, and only reset
    // clears them.
    always_comb begin
        overflow_d  = overflow_q  | (write_valid && full);
        underflow_d = underflow_q | (read_ready && empty);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sync_buffer.sv
// ============================================================================
// tb_fifo_sync_buffer
// ----------------------------------------------------------------------------
// Directed bench for fifo_sync_buffer (DATA_WIDTH=8, DEPTH=8). An expected
// queue models the FIFO contents. Inputs are driven 1 ns after each rising
// edge, and outputs are sampled at that same point.
// ============================================================================
module tb_fifo_sync_buffer;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int CW = $clog2(DP) + 1;

    logic          clk;
    logic          reset;
    logic [DW-1:0] write_data;
    logic          write_valid;
    logic          write_ready;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          read_ready;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
    logic          overflow;
    logic          underflow;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] exp_q[$];

    fifo_sync_buffer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk         (clk),
        .reset       (reset),
        .write_data  (write_data),
        .write_valid (write_valid),
        .write_ready (write_ready),
        .read_data   (read_data),
        .read_valid  (read_valid),
        .read_ready  (read_ready),
        .count       (count),
        .full        (full),
        .empty       (empty)
`ifdef FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
        ,
        .overflow    (overflow),
        .underflow   (underflow)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_valid = 1'b0;
        read_ready  = 1'b0;
        write_data  = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [DW-1:0] d);
        write_data  = d;
        write_valid = 1'b1;
        read_ready  = 1'b0;
        tick();
        exp_q.push_back(d);
        write_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        reset = 1'b1;
        repeat (3) tick();
        exp_q.delete();
        n_cmp++; if (count !== CW'(0)) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL reset_write_ready: got %b want 1", write_ready); end
        n_cmp++; if (read_valid !== 1'b0) begin n_fail++; $display("FAIL reset_read_valid: got %b want 0", read_valid); end
        n_cmp++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL reset_read_data: got %h want 00", read_data); end
`ifdef FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", underflow); end
`endif
    endtask

    task automatic test_fill();
        logic [DW-1:0] d;
        for (int i = 0; i < DP; i++) begin
            d = 8'h11 * DW'(i + 1);
            n_cmp++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL fill_write_ready[%0d]: got %b want 1", i, write_ready); end
            push(d);
            n_cmp++; if (count !== CW'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
        end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
        n_cmp++; if (write_ready !== 1'b0) begin n_fail++; $display("FAIL fill_write_ready_end: got %b want 0", write_ready); end
        n_cmp++; if (read_data !== 8'h11) begin n_fail++; $display("FAIL fill_head: got %h want 11", read_data); end
        n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b want 0", empty); end
    endtask

    task automatic test_drain();
        logic [DW-1:0] d;
        read_ready  = 1'b1;
        write_valid = 1'b0;
        for (int i = 0; i < DP; i++) begin
            d = 8'h11 * DW'(i + 1);
            n_cmp++; if (read_valid !== 1'b1) begin n_fail++; $display("FAIL drain_read_valid[%0d]: got %b want 1", i, read_valid); end
            n_cmp++; if (read_data !== d) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, read_data, d); end
            tick();
            void'(exp_q.pop_front());
        end
        read_ready = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
        n_cmp++; if (count !== CW'(0)) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
        // Pointers are back at entry 0: the next entry must land and read there.
        push(8'h3C);
        n_cmp++; if (read_data !== 8'h3C) begin n_fail++; $display("FAIL drain_ptr_wrap: got %h want 3c", read_data); end
        read_ready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        read_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        write_valid = 1'b1;
        read_ready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d = 8'hB0 + DW'(i);
            write_data = d;
            n_cmp++; if (read_data !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, read_data, exp_q[0]); end
            n_cmp++; if (count !== CW'(3)) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 3", i, count); end
            tick();
            void'(exp_q.pop_front());
            exp_q.push_back(d);
        end
        write_valid = 1'b0;
        n_cmp++; if (count !== CW'(3)) begin n_fail++; $display("FAIL b2b_count_end: got %0d want 3", count); end
        // Drain the remainder and confirm order (expect B7, B8, B9).
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (read_data !== exp_q[0]) begin n_fail++; $display("FAIL b2b_tail[%0d]: got %h want %h", i, read_data, exp_q[0]); end
            tick();
            void'(exp_q.pop_front());
        end
        read_ready = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DP; i++) push(8'hC0 + DW'(i));
        write_data  = 8'hFF;
        write_valid = 1'b1;
        read_ready  = 1'b0;
        tick();
        write_valid = 1'b0;
        n_cmp++; if (count !== CW'(8)) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", count); end
        n_cmp++; if (read_data !== 8'hC0) begin n_fail++; $display("FAIL ovf_head: got %h want c0", read_data); end
`ifdef FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
`endif
        // Full + read + write: the read is accepted and the write is refused.
        write_data  = 8'hEE;
        write_valid = 1'b1;
        read_ready  = 1'b1;
        tick();
        void'(exp_q.pop_front());
        write_valid = 1'b0;
        read_ready  = 1'b0;
        n_cmp++; if (count !== CW'(7)) begin n_fail++; $display("FAIL ovf_fullrw_count: got %0d want 7", count); end
        n_cmp++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_fullrw_ready: got %b want 1", write_ready); end
        read_ready = 1'b1;
        for (int i = 1; i < DP; i++) begin
            n_cmp++; if (read_data !== (8'hC0 + DW'(i))) begin n_fail++; $display("FAIL ovf_contents[%0d]: got %h want %h", i, read_data, 8'hC0 + DW'(i)); end
            tick();
            void'(exp_q.pop_front());
        end
        read_ready = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got %b want 1", empty); end
`ifdef FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL udf_before: got %b want 0", underflow); end
`endif
        // Empty + write + read: the write is accepted and no read happens.
        write_data  = 8'h77;
        write_valid = 1'b1;
        read_ready  = 1'b1;
        tick();
        exp_q.push_back(8'h77);
        write_valid = 1'b0;
        n_cmp++; if (count !== CW'(1)) begin n_fail++; $display("FAIL empty_rw_count: got %0d want 1", count); end
        n_cmp++; if (read_data !== 8'h77) begin n_fail++; $display("FAIL empty_rw_data: got %h want 77", read_data); end
        tick();
        void'(exp_q.pop_front());
        // Read while empty is ignored.
        tick();
        read_ready = 1'b0;
        n_cmp++; if (count !== CW'(0)) begin n_fail++; $display("FAIL udf_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL udf_empty: got %b want 1", empty); end
`ifdef FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL udf_flag: got %b want 1", underflow); end
`endif
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push(8'hD0 + DW'(i));
        n_cmp++; if (count !== CW'(5)) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 5", count); end
        reset       = 1'b0;
        write_data  = 8'hE5;
        write_valid = 1'b1;
        read_ready  = 1'b1;
        tick();
        reset = 1'b1;
        idle_inputs();
        exp_q.delete();
        n_cmp++; if (count !== CW'(0)) begin n_fail++; $display("FAIL mid_count: got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b want 1", empty); end
        n_cmp++; if (read_data !== 8'h00) begin n_fail++; $display("FAIL mid_read_data: got %h want 00", read_data); end
`ifdef FIFO_SYNC_BUFFER_OVERFLOW_FLAG_EN
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_overflow: got %b want 0", overflow); end
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL mid_underflow: got %b want 0", underflow); end
`endif
        push(8'h5A);
        n_cmp++; if (read_valid !== 1'b1) begin n_fail++; $display("FAIL mid_next_valid: got %b want 1", read_valid); end
        n_cmp++; if (read_data !== 8'h5A) begin n_fail++; $display("FAIL mid_next_data: got %h want 5a", read_data); end
        n_cmp++; if (count !== CW'(1)) begin n_fail++; $display("FAIL mid_next_count: got %0d want 1", count); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
